clock_frequency_divider: RTL and testbench



---
 rtl/chess_pkg.sv | 14 +
 rtl/clock_frequency_divider_modn_counter.sv | 27 ++
 rtl/clock_frequency_divider.sv | 46 ++++
 tb/tb_clock_frequency_divider.sv | 133 +++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// Shared clock constants and helpers used by the chess game's slow-domain logic.
package chess_pkg;

  localparam int unsigned SYS_CLK_HZ = 50_000_000;
  localparam int unsigned UI_TICK_HZ = 10;

  // Half-period in source cycles, floored and clamped to at least one cycle.
  function automatic int unsigned halfPeriod(input int unsigned inHz, input int unsigned outHz);
    int unsigned h;
    h = (outHz == 0) ? 1 : inHz / (2 * outHz);
    return (h == 0) ? 1 : h;
  endfunction

endpackage

// File: rtl/clock_frequency_divider_modn_counter.sv
// Modulo-N up counter with a single-cycle wrap indication on the terminal count.
module clock_frequency_divider_modn_counter #(
  parameter int unsigned N     = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic             InClock,
  input  logic             reset,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(N - 1);

  // Equality-only wrap keeps the count inside 0..N-1 by construction.
  assign wrap = (count == LAST);

  always_ff @(posedge InClock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (wrap) begin
      count <= '0;
    end else begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/clock_frequency_divider.sv
// Divides InClock down to a 50%-duty OutClock by toggling a flop every HALF_PERIOD edges.
module clock_frequency_divider
  import chess_pkg::*;
#(
  parameter int unsigned INPUT_FREQUENCY  = SYS_CLK_HZ,
  parameter int unsigned OUTPUT_FREQUENCY = UI_TICK_HZ
) (
  input  logic InClock,
  input  logic reset,
  output logic OutClock
);

  localparam int unsigned HALF_PERIOD = halfPeriod(INPUT_FREQUENCY, OUTPUT_FREQUENCY);
  localparam int unsigned COUNT_WIDTH = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  if (OUTPUT_FREQUENCY == 0 || OUTPUT_FREQUENCY > INPUT_FREQUENCY / 2) begin : genBadRatio
    $error("clock_frequency_divider: OUTPUT_FREQUENCY must be in 1..INPUT_FREQUENCY/2");
  end

  logic [COUNT_WIDTH-1:0] counter;
  logic                   wrap;
  logic                   unusedCount;

  clock_frequency_divider_modn_counter #(
    .N    (HALF_PERIOD),
    .WIDTH(COUNT_WIDTH)
  ) uCounter (
    .InClock(InClock),
    .reset  (reset),
    .count  (counter),
    .wrap   (wrap)
  );

  // The count is kept as a named net for debug visibility only.
  assign unusedCount = ^counter;

  // OutClock comes straight from this flop so downstream sees no combinational glitches.
  always_ff @(posedge InClock or posedge reset) begin
    if (reset) begin
      OutClock <= 1'b0;
    end else if (wrap) begin
      OutClock <= ~OutClock;
    end
  end

endmodule

// File: tb/tb_clock_frequency_divider.sv
// Randomized reset/run stimulus on five divider instances, checked by a queue-based scoreboard.
module tb_clock_frequency_divider;

  typedef struct packed {
    logic [4:0]       out;
    logic [4:0][21:0] cnt;
  } exp_t;

  logic       InClock = 1'b0;
  logic [4:0] rst     = 5'h1F;
  logic [4:0] actOut;

  int checks = 0;
  int errors = 0;
  int pushes = 0;
  int pops   = 0;
  int cycle  = 0;

  int unsigned halfOf [5] = '{5, 1, 16, 50, 2_500_000};
  int unsigned edgeCnt [5] = '{0, 0, 0, 0, 0};
  exp_t        expQ [$];

  always #5 InClock = ~InClock;

  clock_frequency_divider #(.INPUT_FREQUENCY(100), .OUTPUT_FREQUENCY(10)) dutA (
    .InClock(InClock), .reset(rst[0]), .OutClock(actOut[0]));
  clock_frequency_divider #(.INPUT_FREQUENCY(4), .OUTPUT_FREQUENCY(2)) dutB (
    .InClock(InClock), .reset(rst[1]), .OutClock(actOut[1]));
  clock_frequency_divider #(.INPUT_FREQUENCY(100), .OUTPUT_FREQUENCY(3)) dutC (
    .InClock(InClock), .reset(rst[2]), .OutClock(actOut[2]));
  clock_frequency_divider #(.INPUT_FREQUENCY(1001), .OUTPUT_FREQUENCY(10)) dutD (
    .InClock(InClock), .reset(rst[3]), .OutClock(actOut[3]));
  clock_frequency_divider dutE (
    .InClock(InClock), .reset(rst[4]), .OutClock(actOut[4]));

  // Reference: after n edges since release, phase = floor(n/H) mod 2 and count = n mod H.
  task automatic step(input logic [4:0] rstNext);
    logic [4:0] rise;
    exp_t       e;
    @(negedge InClock);
    rise = rstNext & ~rst;
    rst  = rstNext;
    if (rise != 5'd0) begin
      #1;
      for (int i = 0; i < 5; i++) begin
        if (rise[i]) begin
          checks++;
          if (actOut[i] !== 1'b0) begin
            errors++;
            $display("FAIL async_reset[%0d] cycle %0d: got %b required 0", i, cycle, actOut[i]);
          end
        end
      end
    end
    for (int i = 0; i < 5; i++) begin
      if (rst[i]) edgeCnt[i] = 0;
      else edgeCnt[i] = edgeCnt[i] + 1;
      e.out[i] = ((edgeCnt[i] / halfOf[i]) % 2) == 1;
      e.cnt[i] = 22'(edgeCnt[i] % halfOf[i]);
    end
    expQ.push_back(e);
    pushes++;
  endtask

  // Monitor: every rising edge presents a new output sample; compare against the queue head.
  initial begin
    exp_t        e;
    logic [21:0] actCnt [5];
    forever begin
      @(posedge InClock);
      #2;
      cycle++;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        pops++;
        actCnt[0] = 22'(dutA.counter);
        actCnt[1] = 22'(dutB.counter);
        actCnt[2] = 22'(dutC.counter);
        actCnt[3] = 22'(dutD.counter);
        actCnt[4] = 22'(dutE.counter);
        for (int i = 0; i < 5; i++) begin
          checks++;
          if (actOut[i] !== e.out[i]) begin
            errors++;
            $display("FAIL out[%0d] cycle %0d: got %b required %b", i, cycle, actOut[i], e.out[i]);
          end
          checks++;
          if (actCnt[i] !== e.cnt[i]) begin
            errors++;
            $display("FAIL count[%0d] cycle %0d: got %0d required %0d", i, cycle, actCnt[i],
                     e.cnt[i]);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] r;
    for (int k = 0; k < 3; k++) step(5'h1F);
    // Release all; A sits high after its 7th edge, then is reset mid high phase.
    for (int k = 0; k < 7; k++) step(5'h00);
    step(5'h01);
    step(5'h01);
    for (int k = 0; k < 220; k++) step(5'h00);
    r = 5'h00;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 4; i++) begin
        if (r[i]) r[i] = ($urandom_range(0, 3) != 0);
        else r[i] = ($urandom_range(0, 199) == 0);
      end
      step(r);
    end
    step(5'h00);
    repeat (3) @(posedge InClock);
    #3;
    checks++;
    if (expQ.size() != 0 || pops != pushes) begin
      errors++;
      $display("FAIL drain: got %0d pops, %0d left required %0d pops, 0 left", pops, expQ.size(),
               pushes);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
